// File: rtl/seq_pkg.sv
// seq_pkg: shared state type and select constants for decoder_input_sequencer
package seq_pkg;
    typedef enum logic {MANUAL, SCAN} seq_state_t;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] SEL_MAX = 4'd15;
endpackage

// File: rtl/input_debounce.sv
// input_debounce: 2-flop synchronizer plus stable-count debouncer for one raw board input
module input_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DB_CYCLES);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                dout <= s2;
                cnt  <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/decoder_input_sequencer.sv
// decoder_input_sequencer: debounced MANUAL/SCAN select and enable source for the 4-to-16 decoder; define SCAN_BIDIR_EN for a ping-pong scan
module decoder_input_sequencer
    import seq_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic [SEL_W-1:0] SW,
    input  logic             BTNC,
    input  logic             BTNU,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             mode
);
    localparam int PW = $clog2(STEP_CYCLES);
    logic [SEL_W-1:0] sw_db, sel_d;
    logic btnc_db, btnu_db, btnu_q, btnu_press, tick, en_d, mode_d;
    logic [PW-1:0] presc, presc_d;
    seq_state_t state, state_d;
`ifdef SCAN_BIDIR_EN
    logic up, up_d;
`endif

    for (genvar i = 0; i < SEL_W; i++) begin : g_sw
        input_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw (
            .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .din(SW[i]), .dout(sw_db[i])
        );
    end
    input_debounce #(.DB_CYCLES(DB_CYCLES)) u_btnc (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .din(BTNC), .dout(btnc_db)
    );
    input_debounce #(.DB_CYCLES(DB_CYCLES)) u_btnu (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .din(BTNU), .dout(btnu_db)
    );

    assign btnu_press = btnu_db & ~btnu_q;
    assign tick       = presc == PW'(STEP_CYCLES - 1);

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state  <= MANUAL;
            sel    <= '0;
            en     <= 1'b0;
            mode   <= 1'b0;
            presc  <= '0;
            btnu_q <= 1'b0;
`ifdef SCAN_BIDIR_EN
            up     <= 1'b1;
`endif
        end else begin
            state  <= state_d;
            sel    <= sel_d;
            en     <= en_d;
            mode   <= mode_d;
            presc  <= presc_d;
            btnu_q <= btnu_db;
`ifdef SCAN_BIDIR_EN
            up     <= up_d;
`endif
        end
    end

    always_comb state_d = btnu_press ? (state == MANUAL ? SCAN : MANUAL) : state;

    // A press leaving SCAN pre-empts any step tick in the same cycle.
    always_comb begin
        presc_d = presc;
        sel_d   = sel;
`ifdef SCAN_BIDIR_EN
        up_d    = up;
`endif
        if (state_d == MANUAL) sel_d = sw_db;
        else if (state == MANUAL) begin
            sel_d   = '0;
            presc_d = '0;
`ifdef SCAN_BIDIR_EN
            up_d    = 1'b1;
`endif
        end else if (!btnc_db) begin
            presc_d = tick ? '0 : presc + 1'b1;
`ifdef SCAN_BIDIR_EN
            if (tick && ((up && sel == SEL_MAX) || (!up && sel == '0))) up_d = ~up;
            if (tick) sel_d = up_d ? sel + 1'b1 : sel - 1'b1;
`else
            if (tick) sel_d = sel + 1'b1;
`endif
        end
        en_d   = state_d == MANUAL ? btnc_db : 1'b1;
        mode_d = state_d == SCAN;
    end
endmodule
